// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package loader_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Frame parser states.
    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/word_packer.sv
// Packs big-endian bytes into 32-bit words; emits a registered one-cycle word_valid.
module word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              valid_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               word_valid_q, word_valid_d;

    // Shift the first three bytes; the fourth completes the word and fires the strobe.
    always_comb begin
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (valid_i) begin
            if (last_i) begin
                word_d       = {shift_q, byte_i};
                word_valid_d = 1'b1;
            end else begin
                shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_i};
            end
        end
    end

    // Register state; reset drops any partly assembled word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// Framed host byte stream to instruction memory writer with XOR checksum and CPU hold.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DEPTH     = 32,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept_c;
    logic                pack_valid_c;
    logic                pack_last_c;
    logic [LEN_W-1:0]    len_new_c;

    assign accept_c  = in_valid && in_ready_q;
    assign len_new_c = {len_q[LEN_W-1:BYTE_W], in_byte};

    // Next-state, counters, checksum and registered status outputs.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        csum_d       = csum_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        wr_addr_d    = wr_addr_q;
        pack_valid_c = 1'b0;
        pack_last_c  = 1'b0;

        unique case (state_q)
            ST_SYNC: begin
                if (accept_c && (in_byte == SYNC_BYTE)) begin
                    state_d = ST_LEN_HI;
                    csum_d  = '0;
                end
            end
            ST_LEN_HI: begin
                if (accept_c) begin
                    len_d   = {in_byte, len_q[BYTE_W-1:0]};
                    csum_d  = csum_q ^ in_byte;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept_c) begin
                    len_d      = len_new_c;
                    csum_d     = csum_q ^ in_byte;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    if (len_new_c > LEN_W'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else if (len_new_c == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    csum_d       = csum_q ^ in_byte;
                    pack_valid_c = 1'b1;
                    byte_cnt_d   = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        pack_last_c = 1'b1;
                        wr_addr_d   = word_cnt_q;
                        word_cnt_d  = word_cnt_q + ADDR_W'(1);
                        if (word_cnt_q == ADDR_W'(len_q - LEN_W'(1))) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (accept_c) begin
                    state_d = (in_byte == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_SYNC;
        endcase

        in_ready_d = (state_d != ST_DONE) && (state_d != ST_ERR);
        cpu_hold_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            len_q      <= '0;
            csum_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            wr_addr_q  <= '0;
            in_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            wr_addr_q  <= wr_addr_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Word assembly and the write strobe/data registers.
    word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (in_byte),
        .valid_i      (pack_valid_c),
        .last_i       (pack_last_c),
        .word_o       (wr_data),
        .word_valid_o (wr_en)
    );

    assign in_ready = in_ready_q;
    assign wr_addr  = wr_addr_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frame-level reference model, randomized frames and gaps.
module tb_imem_loader;
    import loader_pkg::*;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 32;

    // {done, err, cpu_hold, in_ready}
    localparam logic [3:0] S_RUN  = 4'b0011;
    localparam logic [3:0] S_DONE = 4'b1000;
    localparam logic [3:0] S_ERR  = 4'b0110;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_byte = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { int idx; logic [15:0] addr; logic [31:0] data; } mwr_t;
    typedef struct { logic [15:0] addr; logic [31:0] data; int unsigned cyc; } exp_t;

    logic [7:0] stim_q[$];
    mwr_t       mdl_q[$];
    exp_t       sb_q[$];
    logic [3:0] mdl_status;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: parse the whole byte stream as a frame, list the words and final status.
    task automatic model_run();
        int         i;
        int         n;
        logic [15:0] len;
        logic [7:0]  cs;
        mwr_t        m;
        i = 0;
        n = stim_q.size();
        mdl_q.delete();
        mdl_status = S_RUN;
        while (i < n && stim_q[i] != 8'hA5) i++;
        if (i + 2 >= n) return;
        len = {stim_q[i+1], stim_q[i+2]};
        cs  = stim_q[i+1] ^ stim_q[i+2];
        i += 3;
        if (len > DEPTH) begin
            mdl_status = S_ERR;
            return;
        end
        for (int w = 0; w < int'(len); w++) begin
            if (i + 3 >= n) return;
            m.idx  = i + 3;
            m.addr = 16'(w);
            m.data = {stim_q[i], stim_q[i+1], stim_q[i+2], stim_q[i+3]};
            cs = cs ^ stim_q[i] ^ stim_q[i+1] ^ stim_q[i+2] ^ stim_q[i+3];
            mdl_q.push_back(m);
            i += 4;
        end
        if (i >= n) return;
        mdl_status = (stim_q[i] == cs) ? S_DONE : S_ERR;
    endtask

    // Monitor: every write strobe must match the next expected write, in the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                e = sb_q.pop_front();
                check("write{addr,data,cyc}", {wr_addr, wr_data, 16'(cyc)}, {e.addr, e.data, 16'(e.cyc)});
            end
        end
    end

    // Drive stim_q[start..] with random idle gaps; push expected writes as the completing byte goes out.
    task automatic send(input int start, input int gap_min, input int gap_max);
        int   k;
        exp_t e;
        model_run();
        k = 0;
        while (k < mdl_q.size() && mdl_q[k].idx < start) k++;
        for (int i = start; i < stim_q.size(); i++) begin
            int gap;
            gap = int'($urandom_range(gap_max, gap_min));
            repeat (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = stim_q[i];
            if (k < mdl_q.size() && mdl_q[k].idx == i) begin
                e.addr = mdl_q[k].addr;
                e.data = mdl_q[k].data;
                e.cyc  = cyc + 1;
                sb_q.push_back(e);
                k++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("status{done,err,hold,ready}", 64'({done, err, cpu_hold, in_ready}), 64'(mdl_status));
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        check("pending_writes", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("reset{ready,wr_en,addr,data,hold,done,err}",
              64'({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err}),
              64'({1'b1, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0}));
        sb_q.delete();
    endtask

    task automatic load_normal(input logic [7:0] last);
        stim_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                   8'h00, 8'h22, 8'h18, 8'h00, 8'h1C};
        stim_q[11] = last;
    endtask

    initial begin
        logic [15:0] len;
        logic [7:0]  cs;
        logic [7:0]  b;
        int          sel;

        repeat (2) @(negedge clk);
        do_reset();

        // Normal load.
        load_normal(8'h1C);
        send(0, 0, 0);
        drain();

        // Empty image.
        do_reset();
        stim_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send(0, 0, 0);
        drain();

        // Bad checksum: both writes still happen.
        do_reset();
        load_normal(8'h1D);
        send(0, 0, 0);
        drain();

        // Oversize: error right after LEN_LO, later bytes ignored.
        do_reset();
        stim_q = '{8'hA5, 8'h00, 8'h21};
        send(0, 0, 0);
        stim_q.push_back(8'h00);
        stim_q.push_back(8'h11);
        stim_q.push_back(8'h22);
        stim_q.push_back(8'hA5);
        send(3, 0, 1);
        drain();

        // Leading garbage, then the normal frame with 3-cycle gaps.
        do_reset();
        load_normal(8'h1C);
        stim_q.push_front(8'h5A);
        stim_q.push_front(8'hFF);
        stim_q.push_front(8'h00);
        send(0, 3, 3);
        drain();

        // Reset mid-DATA, then a clean load.
        do_reset();
        stim_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01};
        send(0, 0, 1);
        drain();
        do_reset();
        load_normal(8'h1C);
        send(0, 0, 1);
        drain();

        // Randomized frames.
        for (int t = 0; t < 16; t++) begin
            do_reset();
            stim_q.delete();
            repeat ($urandom_range(3, 0)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                stim_q.push_back(b);
            end
            sel = int'($urandom_range(5, 0));
            case (sel)
                0: len = 16'd0;
                1: len = 16'd1;
                2: len = 16'(DEPTH);
                3: len = 16'(DEPTH + 1);
                4: len = 16'($urandom_range(DEPTH - 1, 2));
                default: len = 16'($urandom_range(16'hFFFF, DEPTH + 1));
            endcase
            stim_q.push_back(8'hA5);
            stim_q.push_back(len[15:8]);
            stim_q.push_back(len[7:0]);
            if (len <= DEPTH) begin
                cs = len[15:8] ^ len[7:0];
                for (int j = 0; j < 4 * int'(len); j++) begin
                    b = 8'($urandom);
                    cs = cs ^ b;
                    stim_q.push_back(b);
                end
                if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
                stim_q.push_back(cs);
            end
            repeat ($urandom_range(2, 0)) stim_q.push_back(8'($urandom));
            send(0, 0, 2);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
